// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding, NZCV bit positions and the latched control payload for alu_seq.
package alu_pkg;

  localparam int unsigned OPW   = 3;
  localparam int unsigned FLAGW = 4;

  localparam logic [OPW-1:0] ALU_ADD  = 3'd0;
  localparam logic [OPW-1:0] ALU_SUB  = 3'd1;
  localparam logic [OPW-1:0] ALU_AND  = 3'd2;
  localparam logic [OPW-1:0] ALU_ORR  = 3'd3;
  localparam logic [OPW-1:0] ALU_EOR  = 3'd4;
  localparam logic [OPW-1:0] ALU_ADC  = 3'd5;
  localparam logic [OPW-1:0] ALU_MUL  = 3'd6;
  localparam logic [OPW-1:0] ALU_RSVD = 3'd7;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  // Control captured at an accepted Start; carry_in is the stored C flag used by ADC.
  typedef struct packed {
    logic [OPW-1:0] op;
    logic           flag_write;
    logic           carry_in;
  } alu_ctrl_t;

  function automatic logic is_arith(input logic [OPW-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_ADC);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier core: one multiplier bit per cycle, low WIDTH product bits.
// Optional ALU_MUL_EARLY_TERM_EN finishes as soon as no multiplier bits remain.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNTW-1:0]  cnt;
  logic             run;
  logic [WIDTH-1:0] addend;

  // product already includes this cycle's partial term so the top can capture it on the last edge
  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    product = acc + addend;
`ifdef ALU_MUL_EARLY_TERM_EN
    last    = run && ((cnt == '0) || (mplier[WIDTH-1:1] == '0));
`else
    last    = run && (cnt == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= A;
      mplier <= B;
      cnt    <= CNTW'(WIDTH - 1);
      run    <= 1'b1;
    end else if (run) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNTW'(1);
      run    <= !last;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with NZCV flag register and Start/Busy/Done handshake.
// Build option ALU_MUL_EARLY_TERM_EN (in alu_mul_seq) enables variable-latency MUL.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             FlagWrite,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);

  state_t           state, state_nx;
  alu_ctrl_t        ctrl_q, ctrl_nx;
  logic [WIDTH-1:0] a_q, a_nx;
  logic [WIDTH-1:0] b_q, b_nx;
  logic             busy_nx;
  logic             done_nx;
  logic [WIDTH-1:0] result_nx;
  logic [3:0]       flags_nx;

  logic             mul_load;
  logic             mul_last;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exec_result;
  logic [3:0]       exec_flags;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .A       (SrcA),
    .B       (SrcB),
    .product (mul_product),
    .last    (mul_last)
  );

  // Single-cycle datapath: SUB reuses the adder as A + ~B + 1
  always_comb begin
    b_eff   = (ctrl_q.op == ALU_SUB) ? ~b_q : b_q;
    cin_eff = 1'b0;
    if (ctrl_q.op == ALU_SUB)      cin_eff = 1'b1;
    else if (ctrl_q.op == ALU_ADC) cin_eff = ctrl_q.carry_in;
    sum = {1'b0, a_q} + {1'b0, b_eff} + (WIDTH+1)'(cin_eff);

    case (ctrl_q.op)
      ALU_ADD, ALU_SUB, ALU_ADC: exec_result = sum[WIDTH-1:0];
      ALU_AND:                   exec_result = a_q & b_q;
      ALU_ORR:                   exec_result = a_q | b_q;
      ALU_EOR:                   exec_result = a_q ^ b_q;
      default:                   exec_result = '0;
    endcase

    exec_flags         = ALUFlags;
    exec_flags[FLAG_N] = exec_result[WIDTH-1];
    exec_flags[FLAG_Z] = (exec_result == '0);
    if (is_arith(ctrl_q.op)) begin
      exec_flags[FLAG_C] = sum[WIDTH];
      exec_flags[FLAG_V] = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (exec_result[WIDTH-1] != a_q[WIDTH-1]);
    end else if (ctrl_q.op == ALU_RSVD) begin
      exec_flags = 4'b0100;
    end
  end

  // Next-state and output logic; Busy stays high through the Done cycle so no Start lands there
  always_comb begin
    state_nx  = state;
    ctrl_nx   = ctrl_q;
    a_nx      = a_q;
    b_nx      = b_q;
    busy_nx   = Busy;
    done_nx   = 1'b0;
    result_nx = ALUResult;
    flags_nx  = ALUFlags;
    mul_load  = 1'b0;

    case (state)
      S_IDLE: begin
        if (Busy) begin
          busy_nx = 1'b0;
        end else if (Start) begin
          ctrl_nx.op         = ALUControl;
          ctrl_nx.flag_write = FlagWrite;
          ctrl_nx.carry_in   = ALUFlags[FLAG_C];
          a_nx               = SrcA;
          b_nx               = SrcB;
          busy_nx            = 1'b1;
          if (ALUControl == ALU_MUL) begin
            mul_load = 1'b1;
            state_nx = S_MUL;
          end else begin
            state_nx = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        result_nx = exec_result;
        if (ctrl_q.flag_write) flags_nx = exec_flags;
        done_nx   = 1'b1;
        state_nx  = S_IDLE;
      end
      S_MUL: begin
        if (mul_last) begin
          result_nx = mul_product;
          if (ctrl_q.flag_write) begin
            flags_nx[FLAG_N] = mul_product[WIDTH-1];
            flags_nx[FLAG_Z] = (mul_product == '0);
          end
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ctrl_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ALUResult <= '0;
      ALUFlags  <= '0;
    end else begin
      state     <= state_nx;
      ctrl_q    <= ctrl_nx;
      a_q       <= a_nx;
      b_q       <= b_nx;
      Busy      <= busy_nx;
      Done      <= done_nx;
      ALUResult <= result_nx;
      ALUFlags  <= flags_nx;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized ops against a signed/unsigned arithmetic model.
module tb_alu_seq;

  localparam int unsigned W = 32;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
                         OP_ADC = 3'd5, OP_MUL = 3'd6;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset;
  logic         Start;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA, SrcB;
  logic         FlagWrite;
  logic         Busy, Done;
  logic [W-1:0] ALUResult;
  logic [3:0]   ALUFlags;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] m_flags;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .FlagWrite  (FlagWrite),
    .Busy       (Busy),
    .Done       (Done),
    .ALUResult  (ALUResult),
    .ALUFlags   (ALUFlags)
  );

  function automatic int mul_lat(input logic [W-1:0] b);
    int h = -1;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
`ifndef ALU_MUL_EARLY_TERM_EN
    h = W - 1;
`endif
    return (h < 0) ? 2 : h + 2;
  endfunction

  // Reference model: math on 64-bit integers, updates m_flags
  task automatic model_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic fw, output logic [W-1:0] res, output int lat);
    longint sa, sb, sv;
    longint unsigned ua, ub, full;
    logic n, z, c, v, arith;
    logic [3:0] f;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    sv = 0;
    c = m_flags[1];
    v = m_flags[0];
    arith = 1'b0;
    case (op)
      3'd0: begin full = ua + ub; sv = sa + sb; c = full[32]; arith = 1'b1; end
      3'd1: begin full = ua - ub; sv = sa - sb; c = (a >= b); arith = 1'b1; end
      3'd2: full = ua & ub;
      3'd3: full = ua | ub;
      3'd4: full = ua ^ ub;
      3'd5: begin
        full = ua + ub + {63'd0, m_flags[1]};
        sv = sa + sb + longint'({63'd0, m_flags[1]});
        c = full[32]; arith = 1'b1;
      end
      3'd6: full = ua * ub;
      default: full = 0;
    endcase
    res = full[31:0];
    if (arith) v = (sv > SMAX) || (sv < SMIN);
    n = res[W-1];
    z = (res == '0);
    f = (op == 3'd7) ? 4'b0100 : {n, z, c, v};
    if (fw) m_flags = f;
    lat = (op == OP_MUL) ? mul_lat(b) : 2;
  endtask

  // Issues one op at the earliest accept cycle and returns the observed Start-to-Done latency (-1 on timeout)
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic fw, output int lat);
    int guard = 0;
    while (Busy === 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
    Start = 1'b1; ALUControl = op; SrcA = a; SrcB = b; FlagWrite = fw;
    @(posedge clk); #1;
    Start = 1'b0; ALUControl = 3'($urandom); SrcA = $urandom; SrcB = $urandom;
    FlagWrite = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= int'(W) + 8; k++) begin
      @(posedge clk); #1;
      if (Done === 1'b1) begin lat = k + 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0; FlagWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", Done); end
    n_tests++; if (ALUResult !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", ALUResult); end
    n_tests++; if (ALUFlags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", ALUFlags); end
    reset = 1'b0;
    m_flags = 4'b0000;
  endtask

  task automatic test_arith();
    logic [W-1:0] r; int el, lat;
    model_op(OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, r, el);
    run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b1, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
    n_tests++; if (ALUResult !== 32'h80000000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", ALUResult); end
    n_tests++; if (ALUFlags !== 4'b1001) begin n_fail++; $display("FAIL add_flags: got %b want 1001", ALUFlags); end
    n_tests++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_done_cycle: got %b want 1", Busy); end

    model_op(OP_SUB, 32'h5, 32'h5, 1'b1, r, el);
    run_op(OP_SUB, 32'h5, 32'h5, 1'b1, lat);
    n_tests++; if (ALUResult !== 32'h0) begin n_fail++; $display("FAIL sub_result: got %h want 0", ALUResult); end
    n_tests++; if (ALUFlags !== 4'b0110) begin n_fail++; $display("FAIL sub_flags: got %b want 0110", ALUFlags); end

    model_op(OP_ADC, 32'h1, 32'h1, 1'b1, r, el);
    run_op(OP_ADC, 32'h1, 32'h1, 1'b1, lat);
    n_tests++; if (ALUResult !== 32'h3) begin n_fail++; $display("FAIL adc_result: got %h want 3", ALUResult); end
    n_tests++; if (ALUFlags !== 4'b0000) begin n_fail++; $display("FAIL adc_flags: got %b want 0000", ALUFlags); end
  endtask

  task automatic test_logic_preserve();
    logic [W-1:0] r; int el, lat;
    model_op(OP_ADD, 32'h80000000, 32'h80000001, 1'b1, r, el);
    run_op(OP_ADD, 32'h80000000, 32'h80000001, 1'b1, lat);
    n_tests++; if (ALUFlags !== 4'b0011) begin n_fail++; $display("FAIL preset_flags: got %b want 0011", ALUFlags); end
    model_op(OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, r, el);
    run_op(OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, lat);
    n_tests++; if (ALUResult !== 32'h0) begin n_fail++; $display("FAIL and_result: got %h want 0", ALUResult); end
    n_tests++; if (ALUFlags !== 4'b0111) begin n_fail++; $display("FAIL and_flags: got %b want 0111", ALUFlags); end
  endtask

  task automatic test_mul();
    logic [W-1:0] r; int el, lat;
    model_op(OP_MUL, 32'h0000FFFF, 32'h00010001, 1'b1, r, el);
    run_op(OP_MUL, 32'h0000FFFF, 32'h00010001, 1'b1, lat);
    n_tests++; if (lat != el) begin n_fail++; $display("FAIL mul_latency: got %0d want %0d", lat, el); end
    n_tests++; if (ALUResult !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mul_result: got %h want ffffffff", ALUResult); end
    n_tests++; if (ALUFlags !== 4'b1011) begin n_fail++; $display("FAIL mul_flags: got %b want 1011", ALUFlags); end
    @(posedge clk); #1;
    n_tests++; if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL mul_after_done: got busy=%b done=%b want 0 0", Busy, Done);
    end
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] a, b, r, seen; int el, dones;
    a = $urandom; b = $urandom | 32'h80000000;
    model_op(OP_MUL, a, b, 1'b1, r, el);
    Start = 1'b1; ALUControl = OP_MUL; SrcA = a; SrcB = b; FlagWrite = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    Start = 1'b1; ALUControl = OP_ADD; SrcA = 32'h1; SrcB = 32'h2; FlagWrite = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    dones = 0; seen = '0;
    for (int k = 0; k < int'(W) + 20; k++) begin
      @(posedge clk); #1;
      if (Done === 1'b1) begin dones++; if (dones == 1) seen = ALUResult; end
    end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL ignored_start_dones: got %0d want 1", dones); end
    n_tests++; if (seen !== r) begin n_fail++; $display("FAIL ignored_start_result: got %h want %h", seen, r); end
    n_tests++; if (ALUFlags !== m_flags) begin n_fail++; $display("FAIL ignored_start_flags: got %b want %b", ALUFlags, m_flags); end
  endtask

  task automatic test_start_on_done();
    logic [W-1:0] a, b, r; int el, lat, dones;
    a = $urandom; b = $urandom;
    model_op(OP_ADD, a, b, 1'b1, r, el);
    run_op(OP_ADD, a, b, 1'b1, lat);
    Start = 1'b1; ALUControl = OP_SUB; SrcA = $urandom; SrcB = $urandom; FlagWrite = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL start_on_done_busy: got %b want 0", Busy); end
    dones = 0;
    repeat (4) begin @(posedge clk); #1; if (Done === 1'b1) dones++; end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL start_on_done_dones: got %0d want 0", dones); end
    n_tests++; if (ALUResult !== r) begin n_fail++; $display("FAIL start_on_done_result: got %h want %h", ALUResult, r); end
  endtask

  task automatic test_random_back_to_back();
    logic [2:0] op; logic [W-1:0] a, b, r; logic fw; int el, lat;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: a = '0; 1: a = '1; 2: a = 32'h80000000; default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = '0; 1: b = '1; 2: b = 32'h7FFFFFFF; default: b = $urandom;
      endcase
      if (op == OP_MUL && $urandom_range(0, 1) == 1) b = b & 32'h000000FF;
      fw = ($urandom_range(0, 3) != 0);
      model_op(op, a, b, fw, r, el);
      run_op(op, a, b, fw, lat);
      n_tests++; if (lat != el) begin n_fail++; $display("FAIL rand%0d_latency op=%0d: got %0d want %0d", i, op, lat, el); end
      n_tests++; if (ALUResult !== r) begin n_fail++; $display("FAIL rand%0d_result op=%0d: got %h want %h", i, op, ALUResult, r); end
      n_tests++; if (ALUFlags !== m_flags) begin n_fail++; $display("FAIL rand%0d_flags op=%0d: got %b want %b", i, op, ALUFlags, m_flags); end
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [W-1:0] r; int dones, lat, el;
    while (Busy === 1'b1) begin @(posedge clk); #1; end
    Start = 1'b1; ALUControl = OP_MUL; SrcA = $urandom | 32'h1; SrcB = $urandom | 32'h80000001; FlagWrite = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_flags = 4'b0000;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", Busy); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", Done); end
    n_tests++; if (ALUResult !== '0) begin n_fail++; $display("FAIL midreset_result: got %h want 0", ALUResult); end
    n_tests++; if (ALUFlags !== 4'b0000) begin n_fail++; $display("FAIL midreset_flags: got %b want 0000", ALUFlags); end
    dones = 0;
    repeat (50) begin @(posedge clk); #1; if (Done === 1'b1) dones++; end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d want 0", dones); end
    model_op(OP_ADC, 32'h10, 32'h20, 1'b1, r, el);
    run_op(OP_ADC, 32'h10, 32'h20, 1'b1, lat);
    n_tests++; if (ALUResult !== r) begin n_fail++; $display("FAIL midreset_recover: got %h want %h", ALUResult, r); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; Start = 1'b0; ALUControl = '0; SrcA = '0; SrcB = '0; FlagWrite = 1'b0;
    m_flags = 4'b0000;
    @(posedge clk); #1;
    test_reset();
    test_arith();
    test_logic_preserve();
    test_mul();
    test_ignored_start();
    test_start_on_done();
    test_random_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
